// File: rtl/axi_pkg.sv
// Shared AXI constants and crossbar FSM state types.
package axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    typedef enum logic [1:0] {
        R_IDLE,
        R_ADDR,
        R_DATA,
        R_ERR
    } rd_state_t;

    typedef enum logic [2:0] {
        W_IDLE,
        W_ADDR,
        W_DATA,
        W_RESP,
        W_EDAT,
        W_ERESP
    } wr_state_t;

endpackage

// File: rtl/axi_addr_decode.sv
// Address decoder: maps an address to a one-hot slave select, lowest index wins.
module axi_addr_decode
    import axi_pkg::*;
#(
    parameter int                          NUM_SLV  = 3,
    parameter int                          ADDR_W   = 32,
    parameter logic [NUM_SLV*ADDR_W-1:0]   SLV_BASE = '0,
    parameter logic [NUM_SLV*ADDR_W-1:0]   SLV_MASK = '0
) (
    input  logic [ADDR_W-1:0]  addr,
    output logic [NUM_SLV-1:0] sel,
    output logic               miss
);

    logic found;

    // Priority scan so overlapping windows resolve to the lowest slave index
    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (!found &&
                ((addr & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W])) begin
                sel[i] = 1'b1;
                found  = 1'b1;
            end
        end
        miss = !found;
    end

endmodule

// File: rtl/axi_xbar_1xn.sv
// 1-master / N-slave AXI4 crossbar with internal DECERR responder.
// Read and write paths are independent, one outstanding burst each.
module axi_xbar_1xn
    import axi_pkg::*;
#(
    parameter int                          NUM_SLV  = 3,
    parameter int                          ADDR_W   = 32,
    parameter int                          DATA_W   = 32,
    parameter int                          ID_W     = 4,
    parameter int                          STRB_W   = DATA_W / 8,
    parameter logic [NUM_SLV*ADDR_W-1:0]   SLV_BASE = '0,
    parameter logic [NUM_SLV*ADDR_W-1:0]   SLV_MASK = '0
) (
    input  logic                        clock,
    input  logic                        reset,
    // master read address
    input  logic [ID_W-1:0]             m_arid,
    input  logic [ADDR_W-1:0]           m_araddr,
    input  logic [7:0]                  m_arlen,
    input  logic [2:0]                  m_arsize,
    input  logic [1:0]                  m_arburst,
    input  logic                        m_arvalid,
    output logic                        m_arready,
    // master read data
    output logic [ID_W-1:0]             m_rid,
    output logic [DATA_W-1:0]           m_rdata,
    output logic [1:0]                  m_rresp,
    output logic                        m_rlast,
    output logic                        m_rvalid,
    input  logic                        m_rready,
    // master write address
    input  logic [ID_W-1:0]             m_awid,
    input  logic [ADDR_W-1:0]           m_awaddr,
    input  logic [7:0]                  m_awlen,
    input  logic [2:0]                  m_awsize,
    input  logic [1:0]                  m_awburst,
    input  logic                        m_awvalid,
    output logic                        m_awready,
    // master write data
    input  logic [ID_W-1:0]             m_wid,
    input  logic [DATA_W-1:0]           m_wdata,
    input  logic [STRB_W-1:0]           m_wstrb,
    input  logic                        m_wlast,
    input  logic                        m_wvalid,
    output logic                        m_wready,
    // master write response
    output logic [ID_W-1:0]             m_bid,
    output logic [1:0]                  m_bresp,
    output logic                        m_bvalid,
    input  logic                        m_bready,
    // slave read address
    output logic [NUM_SLV*ID_W-1:0]     s_arid,
    output logic [NUM_SLV*ADDR_W-1:0]   s_araddr,
    output logic [NUM_SLV*8-1:0]        s_arlen,
    output logic [NUM_SLV*3-1:0]        s_arsize,
    output logic [NUM_SLV*2-1:0]        s_arburst,
    output logic [NUM_SLV-1:0]          s_arvalid,
    input  logic [NUM_SLV-1:0]          s_arready,
    // slave read data
    input  logic [NUM_SLV*ID_W-1:0]     s_rid,
    input  logic [NUM_SLV*DATA_W-1:0]   s_rdata,
    input  logic [NUM_SLV*2-1:0]        s_rresp,
    input  logic [NUM_SLV-1:0]          s_rlast,
    input  logic [NUM_SLV-1:0]          s_rvalid,
    output logic [NUM_SLV-1:0]          s_rready,
    // slave write address
    output logic [NUM_SLV*ID_W-1:0]     s_awid,
    output logic [NUM_SLV*ADDR_W-1:0]   s_awaddr,
    output logic [NUM_SLV*8-1:0]        s_awlen,
    output logic [NUM_SLV*3-1:0]        s_awsize,
    output logic [NUM_SLV*2-1:0]        s_awburst,
    output logic [NUM_SLV-1:0]          s_awvalid,
    input  logic [NUM_SLV-1:0]          s_awready,
    // slave write data
    output logic [NUM_SLV*ID_W-1:0]     s_wid,
    output logic [NUM_SLV*DATA_W-1:0]   s_wdata,
    output logic [NUM_SLV*STRB_W-1:0]   s_wstrb,
    output logic [NUM_SLV-1:0]          s_wlast,
    output logic [NUM_SLV-1:0]          s_wvalid,
    input  logic [NUM_SLV-1:0]          s_wready,
    // slave write response
    input  logic [NUM_SLV*ID_W-1:0]     s_bid,
    input  logic [NUM_SLV*2-1:0]        s_bresp,
    input  logic [NUM_SLV-1:0]          s_bvalid,
    output logic [NUM_SLV-1:0]          s_bready
);

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [NUM_SLV-1:0] ar_hit;
    logic               ar_miss;
    logic [NUM_SLV-1:0] aw_hit;
    logic               aw_miss;

    axi_addr_decode #(
        .NUM_SLV  (NUM_SLV),
        .ADDR_W   (ADDR_W),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK)
    ) u_ar_decode (
        .addr (m_araddr),
        .sel  (ar_hit),
        .miss (ar_miss)
    );

    axi_addr_decode #(
        .NUM_SLV  (NUM_SLV),
        .ADDR_W   (ADDR_W),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK)
    ) u_aw_decode (
        .addr (m_awaddr),
        .sel  (aw_hit),
        .miss (aw_miss)
    );

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    rd_state_t          rd_state;
    logic               arready_q;
    logic [NUM_SLV-1:0] rd_sel;
    logic [7:0]         rd_cnt;
    logic [ID_W-1:0]    ar_id;
    logic [ADDR_W-1:0]  ar_addr;
    logic [7:0]         ar_len;
    logic [2:0]         ar_size;
    logic [1:0]         ar_burst;

    // Captured AR payload; only meaningful while the read FSM is busy
    always_ff @(posedge clock) begin
        if (m_arvalid && m_arready) begin
            ar_id    <= m_arid;
            ar_addr  <= m_araddr;
            ar_len   <= m_arlen;
            ar_size  <= m_arsize;
            ar_burst <= m_arburst;
        end
    end

    // Read FSM; arready is a registered output so it is low out of reset
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_state  <= R_IDLE;
            arready_q <= 1'b0;
            rd_sel    <= '0;
            rd_cnt    <= '0;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    if (arready_q && m_arvalid) begin
                        arready_q <= 1'b0;
                        rd_sel    <= ar_hit;
                        rd_cnt    <= '0;
                        rd_state  <= ar_miss ? R_ERR : R_ADDR;
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                R_ADDR: begin
                    if (|(rd_sel & s_arready)) rd_state <= R_DATA;
                end
                R_DATA: begin
                    if (m_rvalid && m_rready && m_rlast) begin
                        rd_state  <= R_IDLE;
                        arready_q <= 1'b1;
                    end
                end
                R_ERR: begin
                    if (m_rready) begin
                        if (rd_cnt == ar_len) begin
                            rd_state  <= R_IDLE;
                            arready_q <= 1'b1;
                        end else begin
                            rd_cnt <= rd_cnt + 8'd1;
                        end
                    end
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

    assign m_arready = arready_q;
    assign s_arvalid = (rd_state == R_ADDR) ? rd_sel : '0;
    assign s_arid    = {NUM_SLV{ar_id}};
    assign s_araddr  = {NUM_SLV{ar_addr}};
    assign s_arlen   = {NUM_SLV{ar_len}};
    assign s_arsize  = {NUM_SLV{ar_size}};
    assign s_arburst = {NUM_SLV{ar_burst}};

    // R channel: forward the selected slave, or generate DECERR beats
    always_comb begin
        m_rvalid = 1'b0;
        m_rid    = '0;
        m_rdata  = '0;
        m_rresp  = RESP_OKAY;
        m_rlast  = 1'b0;
        s_rready = '0;
        case (rd_state)
            R_DATA: begin
                for (int i = 0; i < NUM_SLV; i++) begin
                    if (rd_sel[i]) begin
                        m_rvalid = s_rvalid[i];
                        m_rid    = s_rid[i*ID_W +: ID_W];
                        m_rdata  = s_rdata[i*DATA_W +: DATA_W];
                        m_rresp  = s_rresp[i*2 +: 2];
                        m_rlast  = s_rlast[i];
                    end
                end
                s_rready = rd_sel & {NUM_SLV{m_rready}};
            end
            R_ERR: begin
                m_rvalid = 1'b1;
                m_rid    = ar_id;
                m_rresp  = RESP_DECERR;
                m_rlast  = (rd_cnt == ar_len);
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
    wr_state_t          wr_state;
    logic               awready_q;
    logic [NUM_SLV-1:0] wr_sel;
    logic [ID_W-1:0]    aw_id;
    logic [ADDR_W-1:0]  aw_addr;
    logic [7:0]         aw_len;
    logic [2:0]         aw_size;
    logic [1:0]         aw_burst;

    // Captured AW payload; only meaningful while the write FSM is busy
    always_ff @(posedge clock) begin
        if (m_awvalid && m_awready) begin
            aw_id    <= m_awid;
            aw_addr  <= m_awaddr;
            aw_len   <= m_awlen;
            aw_size  <= m_awsize;
            aw_burst <= m_awburst;
        end
    end

    // Write FSM; W beats are held off until the AW has reached the slave
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_state  <= W_IDLE;
            awready_q <= 1'b0;
            wr_sel    <= '0;
        end else begin
            case (wr_state)
                W_IDLE: begin
                    if (awready_q && m_awvalid) begin
                        awready_q <= 1'b0;
                        wr_sel    <= aw_hit;
                        wr_state  <= aw_miss ? W_EDAT : W_ADDR;
                    end else begin
                        awready_q <= 1'b1;
                    end
                end
                W_ADDR: begin
                    if (|(wr_sel & s_awready)) wr_state <= W_DATA;
                end
                W_DATA: begin
                    if (m_wvalid && m_wready && m_wlast) wr_state <= W_RESP;
                end
                W_RESP: begin
                    if (m_bvalid && m_bready) begin
                        wr_state  <= W_IDLE;
                        awready_q <= 1'b1;
                    end
                end
                W_EDAT: begin
                    if (m_wvalid && m_wlast) wr_state <= W_ERESP;
                end
                W_ERESP: begin
                    if (m_bready) begin
                        wr_state  <= W_IDLE;
                        awready_q <= 1'b1;
                    end
                end
                default: wr_state <= W_IDLE;
            endcase
        end
    end

    assign m_awready = awready_q;
    assign s_awvalid = (wr_state == W_ADDR) ? wr_sel : '0;
    assign s_awid    = {NUM_SLV{aw_id}};
    assign s_awaddr  = {NUM_SLV{aw_addr}};
    assign s_awlen   = {NUM_SLV{aw_len}};
    assign s_awsize  = {NUM_SLV{aw_size}};
    assign s_awburst = {NUM_SLV{aw_burst}};
    assign s_wid     = {NUM_SLV{m_wid}};
    assign s_wdata   = {NUM_SLV{m_wdata}};
    assign s_wstrb   = {NUM_SLV{m_wstrb}};
    assign s_wlast   = {NUM_SLV{m_wlast}};

    // W/B channels: route to the selected slave or absorb into the error responder
    always_comb begin
        s_wvalid = '0;
        m_wready = 1'b0;
        m_bvalid = 1'b0;
        m_bid    = '0;
        m_bresp  = RESP_OKAY;
        s_bready = '0;
        case (wr_state)
            W_DATA: begin
                s_wvalid = wr_sel & {NUM_SLV{m_wvalid}};
                m_wready = |(wr_sel & s_wready);
            end
            W_RESP: begin
                for (int i = 0; i < NUM_SLV; i++) begin
                    if (wr_sel[i]) begin
                        m_bvalid = s_bvalid[i];
                        m_bid    = s_bid[i*ID_W +: ID_W];
                        m_bresp  = s_bresp[i*2 +: 2];
                    end
                end
                s_bready = wr_sel & {NUM_SLV{m_bready}};
            end
            W_EDAT: begin
                m_wready = 1'b1;
            end
            W_ERESP: begin
                m_bvalid = 1'b1;
                m_bid    = aw_id;
                m_bresp  = RESP_DECERR;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axi_xbar_1xn.sv
// Directed testbench for axi_xbar_1xn with a 3-slave CLINT/MEM/UART map.
module tb_axi_xbar_1xn;

    localparam int NS = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 4;
    localparam int SW = DW / 8;
    localparam logic [NS*AW-1:0] BASE = {32'h1000_0000, 32'h8000_0000, 32'h0200_0000};
    localparam logic [NS*AW-1:0] MASK = {32'hFFFF_F000, 32'hF800_0000, 32'hFFFF_0000};

    logic clock, reset;
    logic [IW-1:0] m_arid;   logic [AW-1:0] m_araddr; logic [7:0] m_arlen;
    logic [2:0] m_arsize;    logic [1:0] m_arburst;   logic m_arvalid, m_arready;
    logic [IW-1:0] m_rid;    logic [DW-1:0] m_rdata;  logic [1:0] m_rresp;
    logic m_rlast, m_rvalid, m_rready;
    logic [IW-1:0] m_awid;   logic [AW-1:0] m_awaddr; logic [7:0] m_awlen;
    logic [2:0] m_awsize;    logic [1:0] m_awburst;   logic m_awvalid, m_awready;
    logic [IW-1:0] m_wid;    logic [DW-1:0] m_wdata;  logic [SW-1:0] m_wstrb;
    logic m_wlast, m_wvalid, m_wready;
    logic [IW-1:0] m_bid;    logic [1:0] m_bresp;     logic m_bvalid, m_bready;
    logic [NS*IW-1:0] s_arid; logic [NS*AW-1:0] s_araddr; logic [NS*8-1:0] s_arlen;
    logic [NS*3-1:0] s_arsize; logic [NS*2-1:0] s_arburst; logic [NS-1:0] s_arvalid, s_arready;
    logic [NS*IW-1:0] s_rid;  logic [NS*DW-1:0] s_rdata; logic [NS*2-1:0] s_rresp;
    logic [NS-1:0] s_rlast, s_rvalid, s_rready;
    logic [NS*IW-1:0] s_awid; logic [NS*AW-1:0] s_awaddr; logic [NS*8-1:0] s_awlen;
    logic [NS*3-1:0] s_awsize; logic [NS*2-1:0] s_awburst; logic [NS-1:0] s_awvalid, s_awready;
    logic [NS*IW-1:0] s_wid;  logic [NS*DW-1:0] s_wdata; logic [NS*SW-1:0] s_wstrb;
    logic [NS-1:0] s_wlast, s_wvalid, s_wready;
    logic [NS*IW-1:0] s_bid;  logic [NS*2-1:0] s_bresp; logic [NS-1:0] s_bvalid, s_bready;

    int checks = 0;
    int errors = 0;
    logic mon_en = 1'b0;
    int side_hits = 0;

    axi_xbar_1xn #(
        .NUM_SLV(NS), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW),
        .SLV_BASE(BASE), .SLV_MASK(MASK)
    ) dut (
        .clock(clock), .reset(reset),
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
        .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
        .m_awburst(m_awburst), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wid(m_wid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
        .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
        .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
        .s_awburst(s_awburst), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wid(s_wid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
        .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Count any activity on slaves that must stay untouched during the UART write
    always @(negedge clock) begin
        if (mon_en && ((s_awvalid[1:0] | s_wvalid[1:0] | s_arvalid) != 0))
            side_hits++;
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs;
        m_arid = '0; m_araddr = '0; m_arlen = '0; m_arsize = 3'd2; m_arburst = 2'b01; m_arvalid = 0;
        m_rready = 0;
        m_awid = '0; m_awaddr = '0; m_awlen = '0; m_awsize = 3'd2; m_awburst = 2'b01; m_awvalid = 0;
        m_wid = '0; m_wdata = '0; m_wstrb = '0; m_wlast = 0; m_wvalid = 0; m_bready = 0;
        s_arready = '0; s_rid = '0; s_rdata = '0; s_rresp = '0; s_rlast = '0; s_rvalid = '0;
        s_awready = '0; s_wready = '0; s_bid = '0; s_bresp = '0; s_bvalid = '0;
    endtask

    task automatic test_reset;
        clear_inputs();
        reset = 1'b1;
        tick(); tick();
        checks++;
        if ({m_arready, m_awready, m_rvalid, m_wready, m_bvalid, s_arvalid, s_awvalid,
             s_wvalid, s_rready, s_bready} !== 16'd0) begin
            errors++;
            $display("FAIL reset_handshakes: got %b required all zero",
                {m_arready, m_awready, m_rvalid, m_wready, m_bvalid, s_arvalid, s_awvalid,
                 s_wvalid, s_rready, s_bready});
        end
        checks++;
        if ({m_rid, m_rdata, m_rresp, m_bid, m_bresp} !== '0) begin
            errors++;
            $display("FAIL reset_payload: rid=%h rdata=%h rresp=%b bid=%h bresp=%b required 0",
                m_rid, m_rdata, m_rresp, m_bid, m_bresp);
        end
        reset = 1'b0;
        tick();
        checks++;
        if ({m_arready, m_awready} !== 2'b11) begin
            errors++;
            $display("FAIL idle_ready: got %b required 11", {m_arready, m_awready});
        end
    endtask

    task automatic test_read_mem;
        m_arid = 4'd5; m_araddr = 32'h8000_0010; m_arlen = 8'd3; m_arvalid = 1;
        tick();
        m_arvalid = 0;
        checks++;
        if ({s_arvalid, s_araddr[AW +: AW], s_arlen[8 +: 8], s_arid[IW +: IW], m_arready}
            !== {3'b010, 32'h8000_0010, 8'd3, 4'd5, 1'b0}) begin
            errors++;
            $display("FAIL rd_fwd_ar: arvalid=%b addr=%h len=%0d id=%0d required 010/80000010/3/5",
                s_arvalid, s_araddr[AW +: AW], s_arlen[8 +: 8], s_arid[IW +: IW]);
        end
        s_arready = 3'b010;
        tick();
        s_arready = '0;
        checks++;
        if (s_arvalid !== 3'b000) begin
            errors++;
            $display("FAIL rd_ar_drop: arvalid=%b required 000", s_arvalid);
        end
        m_rready = 1;
        for (int b = 0; b < 4; b++) begin
            s_rvalid = 3'b010; s_rdata[DW +: DW] = 32'hA0 + b; s_rid[IW +: IW] = 4'd5;
            s_rlast = (b == 3) ? 3'b010 : 3'b000; s_rresp = '0;
            #1;
            checks++;
            if ({m_rvalid, m_rdata, m_rid, m_rlast, m_rresp, s_rready}
                !== {1'b1, 32'hA0 + b, 4'd5, (b == 3), 2'b00, 3'b010}) begin
                errors++;
                $display("FAIL rd_beat%0d: v=%b data=%h id=%0d last=%b rready=%b required 1/%h/5/%0d/010",
                    b, m_rvalid, m_rdata, m_rid, m_rlast, s_rready, 32'hA0 + b, (b == 3));
            end
            tick();
        end
        s_rvalid = '0; s_rlast = '0; m_rready = 0;
        checks++;
        if ({m_rvalid, m_arready} !== 2'b01) begin
            errors++;
            $display("FAIL rd_done: rvalid/arready=%b required 01", {m_rvalid, m_arready});
        end
    endtask

    task automatic test_write_uart;
        side_hits = 0;
        mon_en = 1;
        m_awid = 4'd3; m_awaddr = 32'h1000_0000; m_awlen = 8'd0; m_awvalid = 1;
        m_wid = 4'd3; m_wdata = 32'h1122_3344; m_wstrb = 4'b0001; m_wlast = 1; m_wvalid = 1;
        #1;
        checks++;
        if (m_wready !== 1'b0) begin
            errors++;
            $display("FAIL wr_idle_stall: wready=%b required 0", m_wready);
        end
        tick();
        m_awvalid = 0;
        checks++;
        if ({s_awvalid, s_awaddr[2*AW +: AW], m_wready, s_wvalid}
            !== {3'b100, 32'h1000_0000, 1'b0, 3'b000}) begin
            errors++;
            $display("FAIL wr_fwd_aw: awvalid=%b addr=%h wready=%b wvalid=%b required 100/10000000/0/000",
                s_awvalid, s_awaddr[2*AW +: AW], m_wready, s_wvalid);
        end
        s_awready = 3'b100;
        tick();
        s_awready = '0;
        s_wready = 3'b100;
        #1;
        checks++;
        if ({s_wvalid, s_wdata[2*DW +: DW], s_wstrb[2*SW +: SW], s_wlast[2], m_wready}
            !== {3'b100, 32'h1122_3344, 4'b0001, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL wr_fwd_w: wvalid=%b data=%h strb=%b last=%b wready=%b required 100/11223344/0001/1/1",
                s_wvalid, s_wdata[2*DW +: DW], s_wstrb[2*SW +: SW], s_wlast[2], m_wready);
        end
        tick();
        m_wvalid = 0; m_wlast = 0; s_wready = '0;
        s_bvalid = 3'b100; s_bid[2*IW +: IW] = 4'd3; s_bresp[4 +: 2] = 2'b00; m_bready = 1;
        #1;
        checks++;
        if ({m_bvalid, m_bid, m_bresp, s_bready} !== {1'b1, 4'd3, 2'b00, 3'b100}) begin
            errors++;
            $display("FAIL wr_fwd_b: bvalid=%b bid=%0d bresp=%b bready=%b required 1/3/00/100",
                m_bvalid, m_bid, m_bresp, s_bready);
        end
        tick();
        s_bvalid = '0; m_bready = 0;
        mon_en = 0;
        checks++;
        if ({m_bvalid, m_awready} !== 2'b01 || side_hits !== 0) begin
            errors++;
            $display("FAIL wr_isolation: bvalid/awready=%b stray_cycles=%0d required 01/0",
                {m_bvalid, m_awready}, side_hits);
        end
    endtask

    task automatic test_read_decerr;
        m_arid = 4'd7; m_araddr = 32'h4000_0000; m_arlen = 8'd2; m_arvalid = 1;
        tick();
        m_arvalid = 0;
        // one stalled cycle first: the first error beat must hold
        m_rready = 0;
        #1;
        checks++;
        if ({m_rvalid, m_rlast, m_rresp, s_arvalid} !== {1'b1, 1'b0, 2'b11, 3'b000}) begin
            errors++;
            $display("FAIL rd_err_stall: v=%b last=%b resp=%b arvalid=%b required 1/0/11/000",
                m_rvalid, m_rlast, m_rresp, s_arvalid);
        end
        tick();
        m_rready = 1;
        for (int b = 0; b < 3; b++) begin
            #1;
            checks++;
            if ({m_rvalid, m_rresp, m_rdata, m_rid, m_rlast, s_arvalid}
                !== {1'b1, 2'b11, 32'd0, 4'd7, (b == 2), 3'b000}) begin
                errors++;
                $display("FAIL rd_err_beat%0d: v=%b resp=%b data=%h id=%0d last=%b arvalid=%b required 1/11/0/7/%0d/000",
                    b, m_rvalid, m_rresp, m_rdata, m_rid, m_rlast, s_arvalid, (b == 2));
            end
            tick();
        end
        m_rready = 0;
        checks++;
        if ({m_rvalid, m_arready} !== 2'b01) begin
            errors++;
            $display("FAIL rd_err_done: rvalid/arready=%b required 01", {m_rvalid, m_arready});
        end
    endtask

    task automatic test_write_decerr;
        m_awid = 4'd9; m_awaddr = 32'h4000_0000; m_awlen = 8'd1; m_awvalid = 1;
        tick();
        m_awvalid = 0;
        m_wvalid = 1; m_wdata = 32'hDEAD_0000; m_wstrb = 4'hF; m_wlast = 0;
        #1;
        checks++;
        if ({m_wready, s_wvalid, s_awvalid} !== {1'b1, 3'b000, 3'b000}) begin
            errors++;
            $display("FAIL wr_err_beat0: wready=%b wvalid=%b awvalid=%b required 1/000/000",
                m_wready, s_wvalid, s_awvalid);
        end
        tick();
        m_wdata = 32'hDEAD_0001; m_wlast = 1;
        #1;
        checks++;
        if ({m_wready, m_bvalid} !== 2'b10) begin
            errors++;
            $display("FAIL wr_err_beat1: wready/bvalid=%b required 10", {m_wready, m_bvalid});
        end
        tick();
        m_wvalid = 0; m_wlast = 0;
        m_bready = 0;
        #1;
        checks++;
        if ({m_bvalid, m_bresp, m_bid, m_wready} !== {1'b1, 2'b11, 4'd9, 1'b0}) begin
            errors++;
            $display("FAIL wr_err_resp: bvalid=%b bresp=%b bid=%0d wready=%b required 1/11/9/0",
                m_bvalid, m_bresp, m_bid, m_wready);
        end
        tick();
        checks++;
        if ({m_bvalid, m_bresp, m_bid} !== {1'b1, 2'b11, 4'd9}) begin
            errors++;
            $display("FAIL wr_err_hold: bvalid=%b bresp=%b bid=%0d required 1/11/9", m_bvalid, m_bresp, m_bid);
        end
        m_bready = 1;
        tick();
        m_bready = 0;
        checks++;
        if ({m_bvalid, m_awready} !== 2'b01) begin
            errors++;
            $display("FAIL wr_err_done: bvalid/awready=%b required 01", {m_bvalid, m_awready});
        end
    endtask

    task automatic test_concurrent;
        logic [15:0] rpat;
        logic [15:0] bpat;
        int r_beat;
        logic w_sent, b_done, r_hs, w_hs, b_hs;
        rpat = 16'b1011_0100_1101_0010;
        bpat = 16'b1101_0011_0100_1100;
        r_beat = 0; w_sent = 0; b_done = 0;
        m_arid = 4'd2; m_araddr = 32'h8000_0100; m_arlen = 8'd1; m_arvalid = 1;
        m_awid = 4'd4; m_awaddr = 32'h0200_0004; m_awlen = 8'd0; m_awvalid = 1;
        #1;
        checks++;
        if ({m_arready, m_awready} !== 2'b11) begin
            errors++;
            $display("FAIL cc_accept: ready=%b required 11", {m_arready, m_awready});
        end
        tick();
        m_arvalid = 0; m_awvalid = 0;
        checks++;
        if ({s_arvalid, s_awvalid} !== {3'b010, 3'b001}) begin
            errors++;
            $display("FAIL cc_fwd: arvalid=%b awvalid=%b required 010/001", s_arvalid, s_awvalid);
        end
        s_arready = 3'b010; s_awready = 3'b001;
        tick();
        s_arready = '0; s_awready = '0;
        for (int c = 0; c < 16; c++) begin
            m_rready = rpat[c];
            m_bready = bpat[c];
            if (r_beat < 2) begin
                s_rvalid = 3'b010; s_rdata[DW +: DW] = 32'hB0 + r_beat; s_rid[IW +: IW] = 4'd2;
                s_rlast = (r_beat == 1) ? 3'b010 : 3'b000; s_rresp = '0;
            end else begin
                s_rvalid = '0; s_rlast = '0;
            end
            if (!w_sent) begin
                m_wvalid = 1; m_wlast = 1; m_wdata = 32'hCAFE_0001; m_wstrb = 4'hF; s_wready = 3'b001;
                s_bvalid = '0;
            end else if (!b_done) begin
                m_wvalid = 0; m_wlast = 0; s_wready = '0;
                s_bvalid = 3'b001; s_bid[0 +: IW] = 4'd4; s_bresp[0 +: 2] = 2'b00;
            end else begin
                s_bvalid = '0;
            end
            #1;
            if (r_beat < 2) begin
                checks++;
                if ({m_rvalid, m_rdata, m_rid, m_rlast, s_rready}
                    !== {1'b1, 32'hB0 + r_beat, 4'd2, (r_beat == 1), (rpat[c] ? 3'b010 : 3'b000)}) begin
                    errors++;
                    $display("FAIL cc_r_cyc%0d: v=%b data=%h id=%0d last=%b rready=%b required 1/%h/2/%0d",
                        c, m_rvalid, m_rdata, m_rid, m_rlast, s_rready, 32'hB0 + r_beat, (r_beat == 1));
                end
            end
            if (w_sent && !b_done) begin
                checks++;
                if ({m_bvalid, m_bid, m_bresp} !== {1'b1, 4'd4, 2'b00}) begin
                    errors++;
                    $display("FAIL cc_b_cyc%0d: bvalid=%b bid=%0d bresp=%b required 1/4/00",
                        c, m_bvalid, m_bid, m_bresp);
                end
            end
            r_hs = m_rvalid && m_rready;
            w_hs = m_wvalid && m_wready;
            b_hs = m_bvalid && m_bready;
            tick();
            if (r_hs && r_beat < 2) r_beat++;
            if (w_hs) w_sent = 1;
            if (b_hs && w_sent) b_done = 1;
        end
        clear_inputs();
        checks++;
        if (r_beat !== 2 || b_done !== 1'b1 || {m_arready, m_awready} !== 2'b11) begin
            errors++;
            $display("FAIL cc_complete: rbeats=%0d bdone=%b ready=%b required 2/1/11",
                r_beat, b_done, {m_arready, m_awready});
        end
    endtask

    task automatic test_reset_mid_burst;
        m_arid = 4'd1; m_araddr = 32'h8000_0000; m_arlen = 8'd3; m_arvalid = 1;
        tick();
        m_arvalid = 0;
        s_arready = 3'b010;
        tick();
        s_arready = '0;
        m_rready = 1;
        for (int b = 0; b < 2; b++) begin
            s_rvalid = 3'b010; s_rdata[DW +: DW] = 32'hC0 + b; s_rid[IW +: IW] = 4'd1; s_rlast = '0;
            tick();
        end
        s_rdata[DW +: DW] = 32'hC2;
        #1;
        reset = 1;
        clear_inputs();
        tick();
        checks++;
        if ({m_arready, m_awready, m_rvalid, m_wready, m_bvalid, s_arvalid, s_awvalid,
             s_wvalid, s_rready, s_bready} !== 16'd0) begin
            errors++;
            $display("FAIL rst_mid_burst: got %b required all zero",
                {m_arready, m_awready, m_rvalid, m_wready, m_bvalid, s_arvalid, s_awvalid,
                 s_wvalid, s_rready, s_bready});
        end
        reset = 0;
        tick();
        m_arid = 4'd6; m_araddr = 32'h1000_0010; m_arlen = 8'd0; m_arvalid = 1;
        #1;
        checks++;
        if (m_arready !== 1'b1) begin
            errors++;
            $display("FAIL rst_recover_ready: arready=%b required 1", m_arready);
        end
        tick();
        m_arvalid = 0;
        checks++;
        if (s_arvalid !== 3'b100) begin
            errors++;
            $display("FAIL rst_recover_ar: arvalid=%b required 100", s_arvalid);
        end
        s_arready = 3'b100;
        tick();
        s_arready = '0;
        s_rvalid = 3'b100; s_rdata[2*DW +: DW] = 32'h5555_AAAA; s_rid[2*IW +: IW] = 4'd6;
        s_rlast = 3'b100; m_rready = 1;
        #1;
        checks++;
        if ({m_rvalid, m_rdata, m_rid, m_rlast} !== {1'b1, 32'h5555_AAAA, 4'd6, 1'b1}) begin
            errors++;
            $display("FAIL rst_recover_r: v=%b data=%h id=%0d last=%b required 1/5555aaaa/6/1",
                m_rvalid, m_rdata, m_rid, m_rlast);
        end
        tick();
        clear_inputs();
        checks++;
        if ({m_rvalid, m_arready} !== 2'b01) begin
            errors++;
            $display("FAIL rst_recover_done: rvalid/arready=%b required 01", {m_rvalid, m_arready});
        end
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_read_mem();
        test_write_uart();
        test_read_decerr();
        test_write_decerr();
        test_concurrent();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
